// File: rtl/full_adder_unit.sv
// full_adder_unit: WIDTH-bit ripple-carry adder built from 1-bit full-adder cells.
// It provides a combinational sum/carry path and a one-stage registered copy that is
// qualified by a valid flag.
// Optional: define FULL_ADDER_OVF_EN to add the two's-complement overflow outputs
// ovf (combinational) and ovf_q (registered).
module full_adder_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);

    // carry[i] is the carry into cell i; carry[WIDTH] is the carry out of the MSB cell.
    logic [WIDTH:0]   carry;

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             out_valid_d;
    logic             out_valid_q;

`ifdef FULL_ADDER_OVF_EN
    logic             ovf_d;
`endif

    // Ripple the carry through the chain of 1-bit full-adder cells, from the LSB upward.
    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[WIDTH];

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow occurs when the carry into the MSB differs from the carry out of it.
    // At WIDTH=1, carry[0] is cin, so ovf reduces to cout ^ cin.
    assign ovf = carry[WIDTH] ^ carry[WIDTH-1];
`endif

    // Next state: capture the combinational result when in_valid is high, otherwise hold.
    // out_valid is a single-cycle pulse that follows each capture.
    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = 1'b0;
`ifdef FULL_ADDER_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (in_valid) begin
            sum_d       = sum;
            cout_d      = cout;
            out_valid_d = 1'b1;
`ifdef FULL_ADDER_OVF_EN
            ovf_d       = ovf;
`endif
        end
    end

    // Output register stage. The asynchronous reset discards any capture that is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef FULL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit at WIDTH = 1, 4 and 8.
// It checks the DUT against a reference model written with plain arithmetic.
module tb_full_adder_unit;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_bad;

    // WIDTH=1 instance
    logic       a1, b1, cin1, iv1;
    logic       s1, co1, sq1, cq1, vo1;
    // WIDTH=4 instance
    logic [3:0] a4, b4, s4, sq4;
    logic       cin4, iv4, co4, cq4, vo4;
    // WIDTH=8 instance
    logic [7:0] a8, b8, s8, sq8;
    logic       cin8, iv8, co8, cq8, vo8;
`ifdef FULL_ADDER_OVF_EN
    logic       of1, ofq1, of4, ofq4, of8, ofq8;
`endif

    full_adder_unit #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
        .sum(s1), .cout(co1), .sum_q(sq1), .cout_q(cq1), .out_valid(vo1)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of1), .ovf_q(ofq1)
`endif
    );

    full_adder_unit #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
        .sum(s4), .cout(co4), .sum_q(sq4), .cout_q(cq4), .out_valid(vo4)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of4), .ovf_q(ofq4)
`endif
    );

    full_adder_unit #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .sum(s8), .cout(co8), .sum_q(sq8), .cout_q(cq8), .out_valid(vo8)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of8), .ovf_q(ofq8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for the 4-bit adder: exact unsigned sum, 5 bits wide.
    function automatic logic [4:0] ref_add4(input logic [3:0] x, input logic [3:0] y, input logic c);
        int t;
        t = int'(x) + int'(y) + int'(c);
        return t[4:0];
    endfunction

    // Reference model for signed overflow: the true signed sum falls outside [-8, 7].
    function automatic logic ref_ovf4(input logic [3:0] x, input logic [3:0] y, input logic c);
        int t;
        t = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (t > 7) || (t < -8);
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        a1 = 0; b1 = 0; cin1 = 0; iv1 = 1'b1;
        a4 = '0; b4 = '0; cin4 = 0; iv4 = 1'b1;
        a8 = '0; b8 = '0; cin8 = 0; iv8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (sq1 !== 1'b0 || cq1 !== 1'b0 || vo1 !== 1'b0) begin n_bad++;
            $display("FAIL reset_w1: sum_q=%b cout_q=%b out_valid=%b, required 0 0 0", sq1, cq1, vo1); end
        n_vec++; if (sq4 !== 4'h0 || cq4 !== 1'b0 || vo4 !== 1'b0) begin n_bad++;
            $display("FAIL reset_w4: sum_q=%h cout_q=%b out_valid=%b, required 0 0 0", sq4, cq4, vo4); end
        n_vec++; if (sq8 !== 8'h00 || cq8 !== 1'b0 || vo8 !== 1'b0) begin n_bad++;
            $display("FAIL reset_w8: sum_q=%h cout_q=%b out_valid=%b, required 00 0 0", sq8, cq8, vo8); end
`ifdef FULL_ADDER_OVF_EN
        n_vec++; if (ofq4 !== 1'b0) begin n_bad++;
            $display("FAIL reset_ovf_q: got %b, required 0", ofq4); end
`endif
        // The combinational path must stay live while reset is held.
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1;
        #1;
        n_vec++; if ({co4, s4} !== 5'h12) begin n_bad++;
            $display("FAIL reset_comb_live: {cout,sum}=%h, required 12", {co4, s4}); end
        @(negedge clk);
        iv1 = 0; iv4 = 0; iv8 = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (vo4 !== 1'b0 || sq4 !== 4'h0) begin n_bad++;
            $display("FAIL reset_release_idle: out_valid=%b sum_q=%h, required 0 0", vo4, sq4); end
    endtask

    task automatic test_w1_comb;
        logic [7:0] exp_s;
        logic [7:0] exp_c;
        logic [2:0] v;
        exp_s = 8'b1001_0110;
        exp_c = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0];
            #5;
            n_vec++; if (s1 !== exp_s[i] || co1 !== exp_c[i]) begin n_bad++;
                $display("FAIL w1_comb[%0d]: sum/cout=%b/%b, required %b/%b", i, s1, co1, exp_s[i], exp_c[i]); end
`ifdef FULL_ADDER_OVF_EN
            n_vec++; if (of1 !== (exp_c[i] ^ v[0])) begin n_bad++;
                $display("FAIL w1_ovf[%0d]: got %b, required %b", i, of1, exp_c[i] ^ v[0]); end
`endif
        end
    endtask

    task automatic test_w1_reg;
        @(negedge clk);
        a1 = 1; b1 = 1; cin1 = 1; iv1 = 1;
        @(posedge clk); #1;
        n_vec++; if (sq1 !== 1'b1 || cq1 !== 1'b1 || vo1 !== 1'b1) begin n_bad++;
            $display("FAIL w1_capture: sum_q=%b cout_q=%b out_valid=%b, required 1 1 1", sq1, cq1, vo1); end
        @(negedge clk);
        a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
        @(posedge clk); #1;
        n_vec++; if (sq1 !== 1'b1 || cq1 !== 1'b1 || vo1 !== 1'b0) begin n_bad++;
            $display("FAIL w1_hold: sum_q=%b cout_q=%b out_valid=%b, required 1 1 0", sq1, cq1, vo1); end
    endtask

    task automatic test_w8_boundary;
        logic [7:0] ta [4];
        logic [7:0] tb [4];
        logic       tc [4];
        logic [8:0] te [4];
        ta = '{8'hFF, 8'h5A, 8'hFF, 8'h00};
        tb = '{8'h00, 8'h33, 8'hFF, 8'h00};
        tc = '{1'b1,  1'b0,  1'b1,  1'b0};
        te = '{9'h100, 9'h08D, 9'h1FF, 9'h000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a8 = ta[i]; b8 = tb[i]; cin8 = tc[i]; iv8 = 1'b1;
            #1;
            n_vec++; if ({co8, s8} !== te[i]) begin n_bad++;
                $display("FAIL w8_comb[%0d]: {cout,sum}=%h, required %h", i, {co8, s8}, te[i]); end
            @(posedge clk); #1;
            n_vec++; if ({cq8, sq8} !== te[i] || vo8 !== 1'b1) begin n_bad++;
                $display("FAIL w8_reg[%0d]: {cout_q,sum_q}=%h out_valid=%b, required %h 1", i, {cq8, sq8}, vo8, te[i]); end
        end
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [4:0] e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); iv4 = 1'b1;
        end
        @(negedge clk);
        a4 = 4'h6; b4 = 4'h7; cin4 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (sq4 !== 4'h0 || cq4 !== 1'b0 || vo4 !== 1'b0) begin n_bad++;
            $display("FAIL midreset_async: sum_q=%h cout_q=%b out_valid=%b, required 0 0 0", sq4, cq4, vo4); end
        n_vec++; if ({co4, s4} !== 5'h0E) begin n_bad++;
            $display("FAIL midreset_comb: {cout,sum}=%h, required 0e", {co4, s4}); end
        @(posedge clk); #1;
        n_vec++; if (vo4 !== 1'b0 || sq4 !== 4'h0) begin n_bad++;
            $display("FAIL midreset_discard: out_valid=%b sum_q=%h, required 0 0", vo4, sq4); end
        @(negedge clk);
        a4 = 4'hB; b4 = 4'h9; cin4 = 1'b0; iv4 = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        n_vec++; if (vo4 !== 1'b0) begin n_bad++;
            $display("FAIL midreset_release: out_valid=%b, required 0", vo4); end
        e = ref_add4(4'hB, 4'h9, 1'b0);
        @(posedge clk); #1;
        n_vec++; if ({cq4, sq4} !== e || vo4 !== 1'b1) begin n_bad++;
            $display("FAIL midreset_first_capture: {cout_q,sum_q}=%h out_valid=%b, required %h 1", {cq4, sq4}, vo4, e); end
    endtask

    task automatic test_random_w4;
        logic [4:0] exp_q;
        logic       exp_vld;
        logic [4:0] e;
`ifdef FULL_ADDER_OVF_EN
        logic       exp_ovq;
        exp_ovq = 1'b0;
`endif
        exp_q = '0;
        exp_vld = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            iv4 = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            e = ref_add4(a4, b4, cin4);
            #1;
            n_vec++; if ({co4, s4} !== e) begin n_bad++;
                $display("FAIL rand_comb[%0d]: a=%h b=%h cin=%b {cout,sum}=%h, required %h", i, a4, b4, cin4, {co4, s4}, e); end
`ifdef FULL_ADDER_OVF_EN
            n_vec++; if (of4 !== ref_ovf4(a4, b4, cin4)) begin n_bad++;
                $display("FAIL rand_ovf[%0d]: got %b, required %b", i, of4, ref_ovf4(a4, b4, cin4)); end
`endif
            @(posedge clk);
            exp_vld = iv4;
            if (iv4) begin
                exp_q = e;
`ifdef FULL_ADDER_OVF_EN
                exp_ovq = ref_ovf4(a4, b4, cin4);
`endif
            end
            #1;
            n_vec++; if ({cq4, sq4} !== exp_q || vo4 !== exp_vld) begin n_bad++;
                $display("FAIL rand_reg[%0d]: {cout_q,sum_q}=%h out_valid=%b, required %h %b", i, {cq4, sq4}, vo4, exp_q, exp_vld); end
`ifdef FULL_ADDER_OVF_EN
            n_vec++; if (ofq4 !== exp_ovq) begin n_bad++;
                $display("FAIL rand_ovf_q[%0d]: got %b, required %b", i, ofq4, exp_ovq); end
`endif
        end
    endtask

`ifdef FULL_ADDER_OVF_EN
    task automatic test_ovf;
        logic [3:0] ta [3];
        logic [3:0] tb [3];
        logic       te [3];
        ta = '{4'h7, 4'h8, 4'h3};
        tb = '{4'h1, 4'hF, 4'h2};
        te = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a4 = ta[i]; b4 = tb[i]; cin4 = 1'b0; iv4 = 1'b0;
            #1;
            n_vec++; if (of4 !== te[i]) begin n_bad++;
                $display("FAIL ovf_directed[%0d]: got %b, required %b", i, of4, te[i]); end
        end
        a4 = 4'h8; b4 = 4'hF; cin4 = 1'b0;
        #1;
        n_vec++; if (s4 !== 4'h7 || co4 !== 1'b1) begin n_bad++;
            $display("FAIL ovf_sum: sum=%h cout=%b, required 7 1", s4, co4); end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_w1_comb();
        test_w1_reg();
        test_w8_boundary();
        test_reset_mid();
`ifdef FULL_ADDER_OVF_EN
        test_ovf();
`endif
        test_random_w4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/full_adder_unit.md
Name: full_adder_unit

Overview:
- Binary full adder, WIDTH bits, built as a ripple-carry chain of 1-bit full-adder cells.
- At WIDTH=1 it is the canonical 1-bit full adder.
- Provides a purely combinational sum/carry path plus a one-stage registered copy with valid qualification.
- Used standalone as an arithmetic leaf cell and as a building block for wider datapath adders.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock for the registered stage.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A (bit 0 = LSB).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in into bit 0.
- in_valid  input  1  qualifies a/b/cin for capture into the registered stage.
- sum  output  WIDTH  combinational sum, (a + b + cin) mod 2^WIDTH.
- cout  output  1  combinational carry-out of the MSB cell.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry-out.
- out_valid  output  1  registered valid; high for the cycle after an in_valid capture.

Behaviour:
- Per-bit cell i:
  - s_i = a_i XOR b_i XOR c_i.
  - c_(i+1) = (a_i AND b_i) OR (c_i AND (a_i XOR b_i)).
  - c_0 = cin.
- cout = c_WIDTH; {cout, sum} = a + b + cin exactly, as a WIDTH+1-bit unsigned result.
- sum and cout are combinational:
  - zero-cycle latency; they update whenever a, b or cin change, independent of clk, rst_n and in_valid.
  - No X-propagation beyond what the inputs carry; fully defined for all 2^(2*WIDTH+1) input combinations.
- Registered stage, on rising clk:
  - if in_valid=1: sum_q<=sum, cout_q<=cout, out_valid<=1.
  - if in_valid=0: sum_q and cout_q hold, out_valid<=0.
- Latency of the registered path: exactly 1 cycle. Back-to-back in_valid=1 gives one result per cycle with no bubbles.
- Reset, while rst_n=0 (asynchronous assert, synchronous-to-clk deassert behaviour at the next edge):
  - sum_q=0, cout_q=0, out_valid=0.
  - The combinational sum and cout remain live during reset.
- Reset mid-operation: a capture pending at the reset edge is discarded, and out_valid stays 0 until the first in_valid after release.
- Boundary conditions:
  - All-ones operands with cin=1 give sum=all-ones, cout=1.
  - All-zero operands with cin=0 give sum=0, cout=0.
  - Maximum overflow (e.g. a=all-ones, b=0, cin=1) gives sum=0, cout=1.

Optional Feature:
- Macro FULL_ADDER_OVF_EN.
- Defined: adds outputs ovf (combinational) and ovf_q (registered alongside sum_q, reset to 0).
  - ovf = c_WIDTH XOR c_(WIDTH-1), i.e. two's-complement signed overflow.
  - At WIDTH=1, ovf = cout XOR cin.
- Not defined: neither port exists and behaviour is otherwise identical.

Test Plan:
- WIDTH=1, combinational, step a,b,cin through 000..111 every 5 ns -> sum/cout = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
- WIDTH=1, registered: in_valid=1 with a=1,b=1,cin=1 -> sum_q=1, cout_q=1, out_valid=1 one clk later; in_valid=0 next cycle -> out_valid=0, sum_q/cout_q hold.
- WIDTH=8: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1; a=0x5A, b=0x33, cin=0 -> sum=0x8D, cout=0.
- Reset: hold in_valid=1 streaming, assert rst_n=0 between edges -> sum_q=0, cout_q=0, out_valid=0 immediately while sum/cout still track inputs; after release the first capture appears 1 cycle later.
- WIDTH=4, random 1000 vectors with in_valid random -> {cout,sum} equals a+b+cin; registered outputs equal the prior-cycle combinational values.
- FULL_ADDER_OVF_EN, WIDTH=4: a=0x7, b=0x1, cin=0 -> ovf=1; a=0x8, b=0xF, cin=0 -> sum=0x7, cout=1, ovf=1; a=0x3, b=0x2 -> ovf=0.
